weight_dump_tx: RTL and testbench
=================================

WEIGHT_DUMP_TX -- requirements
Module: weight_dump_tx

Interface
REQ-001 SHALL have parameter CMD_BYTE, default 8'hCE, command byte that triggers a dump.
REQ-002 SHALL have parameter ERR_BYTE, default 8'hEE, byte sent when a dump is requested before weights are loaded.
REQ-003 SHALL have port clk  input  1  system clock, 100 MHz; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rx_data  input  8  routed command byte.
REQ-006 SHALL have port rx_ready  input  1  one-cycle strobe qualifying rx_data.
REQ-007 SHALL have port weights_loaded  input  1  level; weight memories are valid.
REQ-008 SHALL have port conv_w_addr  output  6  conv weight RAM read address.
REQ-009 SHALL have port conv_w_data  input  8  conv weight RAM read data, 1-cycle latency.
REQ-010 SHALL have port conv_b_addr  output  4  conv bias RAM read address.
REQ-011 SHALL have port conv_b_data  input  32  conv bias RAM read data, 1-cycle latency.
REQ-012 SHALL have port dense_w_addr  output  15  dense weight RAM read address.
REQ-013 SHALL have port dense_w_data  input  8  dense weight RAM read data, 1-cycle latency.
REQ-014 SHALL have port dense_b_addr  output  4  dense bias RAM read address.
REQ-015 SHALL have port dense_b_data  input  32  dense bias RAM read data, 1-cycle latency.
REQ-016 SHALL have port tx_data  output  8  byte to UART transmitter.
REQ-017 SHALL have port tx_send  output  1  one-cycle send strobe.
REQ-018 SHALL have port tx_busy  input  1  UART transmitter busy, rises the cycle after tx_send.
REQ-019 SHALL have port dump_active  output  1  high from command accept to the last byte done; top uses it to grant the dense weight RAM port and the TX mux.

Function
REQ-020 SHALL accept a command only in IDLE, on rx_ready=1 with rx_data=CMD_BYTE; all other bytes and all bytes received while active are ignored.
REQ-021 SHALL send the single byte ERR_BYTE and return to IDLE if weights_loaded=0 at accept.
REQ-022 SHALL otherwise send the frame 0xAA, 0x55, conv_w[0..35], conv_b[0..3], dense_w[0..27039], dense_b[0..9], checksum; total 27135 bytes.
REQ-023 SHALL serialise each 32-bit bias little-endian, 4 bytes per word, reading each word once.
REQ-024 SHALL compute checksum as the 8-bit modulo-256 sum of all payload bytes, excluding header and checksum.
REQ-025 SHALL use states IDLE, FETCH (drive address), LATCH (capture data after 1 cycle), SEND, WAIT_HI, WAIT_LO, NEXT; section index (HDR, CW, CB, DW, DB, CSUM) and element/byte counters select the next byte.
REQ-026 SHALL assert tx_send for exactly one cycle in SEND, only when tx_busy=0, with tx_data stable from that cycle until tx_busy falls.
REQ-027 SHALL wait in WAIT_HI for tx_busy=1, then in WAIT_LO for tx_busy=0, before advancing; there is no timeout.
REQ-028 SHALL advance counters at section end without skipping or repeating: CW at 35, CB at word 3 byte 3, DW at 27039, DB at word 9 byte 3.
REQ-029 SHALL deassert dump_active one cycle after tx_busy falls following the checksum byte or the error byte.
REQ-030 SHALL hold all address outputs at 0 and tx_send at 0 in IDLE.

Reset
REQ-031 SHALL on rst=1, including mid-frame, go to IDLE within one cycle: tx_send=0, tx_data=0, dump_active=0, all addresses 0, counters and checksum cleared; the partial frame is abandoned.

Structure
REQ-032 SHALL take section sizes (36, 4, 27040, 10), header bytes and command bytes (0xCC, 0xCD, 0xCE, 0xEE) from a shared cnn_protocol_pkg also used by the loaders and readers.
REQ-033 SHALL be a single module with no sub-modules; byte-lane selection and checksum are inline.

Verification
REQ-034 SHALL cover weights_loaded=1 with RAMs preloaded with known patterns, command 0xCE -> exactly 27135 bytes in order; checksum equals the model sum; dump_active then falls.
REQ-035 SHALL cover conv_b[0]=32'h11223344 -> bytes 38..41 of the frame are 44,33,22,11.
REQ-036 SHALL cover weights_loaded=0, command 0xCE -> single byte 0xEE, then idle.
REQ-037 SHALL cover bytes 0xCE and 0xCC injected mid-dump -> ignored; the frame is unchanged and no second dump occurs.
REQ-038 SHALL cover rst pulsed at byte 1000 -> tx_send stays 0 afterwards; a new 0xCE restarts from header 0xAA.
REQ-039 SHALL cover tx_busy held high for 5000 cycles on one byte -> no extra tx_send; the frame continues correctly.

Source files
------------

// File: rtl/cnn_protocol_pkg.sv
// Shared CNN link protocol constants: section sizes, frame header and command bytes,
// plus the dump transmitter's state and section encodings.
package cnn_protocol_pkg;

  localparam int CONV_W_LEN  = 36;
  localparam int CONV_B_LEN  = 4;
  localparam int DENSE_W_LEN = 27040;
  localparam int DENSE_B_LEN = 10;

  localparam logic [7:0] HDR_BYTE0      = 8'hAA;
  localparam logic [7:0] HDR_BYTE1      = 8'h55;
  localparam logic [7:0] CMD_LOAD_CONV  = 8'hCC;
  localparam logic [7:0] CMD_LOAD_DENSE = 8'hCD;
  localparam logic [7:0] CMD_DUMP       = 8'hCE;
  localparam logic [7:0] RSP_ERR        = 8'hEE;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_LATCH   = 3'd2;
  localparam logic [2:0] ST_SEND    = 3'd3;
  localparam logic [2:0] ST_WAIT_HI = 3'd4;
  localparam logic [2:0] ST_WAIT_LO = 3'd5;
  localparam logic [2:0] ST_NEXT    = 3'd6;

  localparam logic [2:0] SEC_HDR  = 3'd0;
  localparam logic [2:0] SEC_CW   = 3'd1;
  localparam logic [2:0] SEC_CB   = 3'd2;
  localparam logic [2:0] SEC_DW   = 3'd3;
  localparam logic [2:0] SEC_DB   = 3'd4;
  localparam logic [2:0] SEC_CSUM = 3'd5;

endpackage

// File: rtl/weight_dump_tx.sv
// Streams all CNN weight memories out over the UART as one framed, checksummed dump
// when the dump command arrives; answers with an error byte if weights are not loaded.
module weight_dump_tx
  import cnn_protocol_pkg::*;
#(
  parameter logic [7:0] CMD_BYTE = CMD_DUMP,
  parameter logic [7:0] ERR_BYTE = RSP_ERR,
  // Dense weight section length; the protocol value is the default.
  parameter int         DW_LEN   = DENSE_W_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  input  logic        weights_loaded,
  output logic [5:0]  conv_w_addr,
  input  logic [7:0]  conv_w_data,
  output logic [3:0]  conv_b_addr,
  input  logic [31:0] conv_b_data,
  output logic [14:0] dense_w_addr,
  input  logic [7:0]  dense_w_data,
  output logic [3:0]  dense_b_addr,
  input  logic [31:0] dense_b_data,
  output logic [7:0]  tx_data,
  output logic        tx_send,
  input  logic        tx_busy,
  output logic        dump_active,
  output logic [2:0]  dbg_state_o
);

  // Handshake: tx_send pulses for one cycle only while tx_busy=0; tx_data is held
  // from that cycle until tx_busy falls again, and the next byte waits for that fall.

  localparam logic [14:0] CW_LAST = 15'(CONV_W_LEN - 1);
  localparam logic [14:0] CB_LAST = 15'(CONV_B_LEN - 1);
  localparam logic [14:0] DW_LAST = 15'(DW_LEN - 1);
  localparam logic [14:0] DB_LAST = 15'(DENSE_B_LEN - 1);

  logic [2:0]  state_q, state_d;
  logic [2:0]  sec_q, sec_d;
  logic [14:0] idx_q, idx_d;
  logic [1:0]  lane_q, lane_d;
  logic [7:0]  csum_q, csum_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [31:0] word_q, word_d;
  logic        active_q, active_d;
  logic        err_q, err_d;

  logic [31:0] bias_word;
  logic [7:0]  ram_byte;
  logic [7:0]  held_byte;
  logic        is_payload;

  always_comb begin
    bias_word  = (sec_q == SEC_CB) ? conv_b_data : dense_b_data;
    is_payload = (sec_q == SEC_CW) || (sec_q == SEC_CB) ||
                 (sec_q == SEC_DW) || (sec_q == SEC_DB);
    case (sec_q)
      SEC_HDR:        ram_byte = (idx_q == 15'd0) ? HDR_BYTE0 : HDR_BYTE1;
      SEC_CW:         ram_byte = conv_w_data;
      SEC_CB, SEC_DB: ram_byte = bias_word[7:0];
      SEC_DW:         ram_byte = dense_w_data;
      default:        ram_byte = csum_q;
    endcase
    // Upper lanes of a bias word come from the copy latched with lane 0.
    case (lane_q)
      2'd0:    held_byte = word_q[15:8];
      2'd1:    held_byte = word_q[23:16];
      default: held_byte = word_q[31:24];
    endcase
  end

  always_comb begin
    conv_w_addr  = (active_q && sec_q == SEC_CW) ? idx_q[5:0] : 6'd0;
    conv_b_addr  = (active_q && sec_q == SEC_CB) ? idx_q[3:0] : 4'd0;
    dense_w_addr = (active_q && sec_q == SEC_DW) ? idx_q      : 15'd0;
    dense_b_addr = (active_q && sec_q == SEC_DB) ? idx_q[3:0] : 4'd0;
    tx_send      = (state_q == ST_SEND) && !tx_busy;
    tx_data      = tx_data_q;
    dump_active  = active_q;
    dbg_state_o  = state_q;
  end

  always_comb begin
    state_d   = state_q;
    sec_d     = sec_q;
    idx_d     = idx_q;
    lane_d    = lane_q;
    csum_d    = csum_q;
    tx_data_d = tx_data_q;
    word_d    = word_q;
    active_d  = active_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (rx_ready && rx_data == CMD_BYTE) begin
          active_d = 1'b1;
          sec_d    = SEC_HDR;
          idx_d    = 15'd0;
          lane_d   = 2'd0;
          csum_d   = 8'd0;
          if (!weights_loaded) begin
            err_d     = 1'b1;
            tx_data_d = ERR_BYTE;
            state_d   = ST_SEND;
          end else begin
            err_d   = 1'b0;
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: begin
        tx_data_d = ram_byte;
        word_d    = bias_word;
        if (is_payload) csum_d = csum_q + ram_byte;
        state_d = ST_SEND;
      end
      ST_SEND:    if (!tx_busy) state_d = ST_WAIT_HI;
      ST_WAIT_HI: if (tx_busy)  state_d = ST_WAIT_LO;
      ST_WAIT_LO: begin
        if (!tx_busy) begin
          if (err_q || sec_q == SEC_CSUM) begin
            state_d  = ST_IDLE;
            active_d = 1'b0;
            err_d    = 1'b0;
            sec_d    = SEC_HDR;
            idx_d    = 15'd0;
            lane_d   = 2'd0;
            csum_d   = 8'd0;
          end else begin
            state_d = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        state_d = ST_FETCH;
        case (sec_q)
          SEC_HDR: begin
            if (idx_q == 15'd0) idx_d = 15'd1;
            else begin
              sec_d = SEC_CW;
              idx_d = 15'd0;
            end
          end
          SEC_CW: begin
            if (idx_q == CW_LAST) begin
              sec_d  = SEC_CB;
              idx_d  = 15'd0;
              lane_d = 2'd0;
            end else idx_d = idx_q + 15'd1;
          end
          SEC_CB, SEC_DB: begin
            if (lane_q != 2'd3) begin
              lane_d    = lane_q + 2'd1;
              tx_data_d = held_byte;
              csum_d    = csum_q + held_byte;
              state_d   = ST_SEND;
            end else if (sec_q == SEC_CB && idx_q == CB_LAST) begin
              sec_d  = SEC_DW;
              idx_d  = 15'd0;
              lane_d = 2'd0;
            end else if (sec_q == SEC_DB && idx_q == DB_LAST) begin
              sec_d  = SEC_CSUM;
              idx_d  = 15'd0;
              lane_d = 2'd0;
            end else begin
              idx_d  = idx_q + 15'd1;
              lane_d = 2'd0;
            end
          end
          SEC_DW: begin
            if (idx_q == DW_LAST) begin
              sec_d  = SEC_DB;
              idx_d  = 15'd0;
              lane_d = 2'd0;
            end else idx_d = idx_q + 15'd1;
          end
          default: state_d = ST_IDLE;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sec_q     <= SEC_HDR;
      idx_q     <= 15'd0;
      lane_q    <= 2'd0;
      csum_q    <= 8'd0;
      tx_data_q <= 8'd0;
      word_q    <= 32'd0;
      active_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sec_q     <= sec_d;
      idx_q     <= idx_d;
      lane_q    <= lane_d;
      csum_q    <= csum_d;
      tx_data_q <= tx_data_d;
      word_q    <= word_d;
      active_q  <= active_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_weight_dump_tx.sv
// Directed bench for weight_dump_tx: RAM and UART models, a byte monitor and a
// frame model built from the RAM contents.
module tb_weight_dump_tx;

  localparam int DW_N    = 1200;
  localparam int FRAME_N = 2 + 36 + 4 * 4 + DW_N + 10 * 4 + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        weights_loaded;
  logic [5:0]  conv_w_addr;
  logic [7:0]  conv_w_data;
  logic [3:0]  conv_b_addr;
  logic [31:0] conv_b_data;
  logic [14:0] dense_w_addr;
  logic [7:0]  dense_w_data;
  logic [3:0]  dense_b_addr;
  logic [31:0] dense_b_data;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic        tx_busy;
  logic        dump_active;
  logic [2:0]  dbg_state;

  logic [7:0]  cw_mem [0:35];
  logic [31:0] cb_mem [0:3];
  logic [7:0]  dw_mem [0:DW_N-1];
  logic [31:0] db_mem [0:9];

  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];
  logic [7:0] model_csum;

  int n_assert = 0;
  int n_fail   = 0;
  int busy_cnt = 0;
  int uart_sends = 0;
  int hold_target = -1;

  weight_dump_tx #(.DW_LEN(DW_N)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
    .weights_loaded(weights_loaded),
    .conv_w_addr(conv_w_addr), .conv_w_data(conv_w_data),
    .conv_b_addr(conv_b_addr), .conv_b_data(conv_b_data),
    .dense_w_addr(dense_w_addr), .dense_w_data(dense_w_data),
    .dense_b_addr(dense_b_addr), .dense_b_data(dense_b_data),
    .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy),
    .dump_active(dump_active), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    conv_w_data  <= cw_mem[conv_w_addr];
    conv_b_data  <= cb_mem[conv_b_addr];
    dense_w_data <= dw_mem[dense_w_addr];
    dense_b_data <= db_mem[dense_b_addr];
  end

  // UART: busy rises the cycle after a send, normally for one cycle.
  always @(posedge clk) begin
    if (tx_send) begin
      busy_cnt   <= (uart_sends == hold_target) ? 5000 : 1;
      uart_sends <= uart_sends + 1;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end
  assign tx_busy = (busy_cnt != 0);

  always @(negedge clk) if (tx_send) cap_q.push_back(tx_data);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_frame();
    exp_q.delete();
    model_csum = 8'd0;
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h55);
    for (int i = 0; i < 36; i++) exp_q.push_back(cw_mem[i]);
    for (int i = 0; i < 4; i++)
      for (int b = 0; b < 4; b++) exp_q.push_back(8'(cb_mem[i] >> (8 * b)));
    for (int i = 0; i < DW_N; i++) exp_q.push_back(dw_mem[i]);
    for (int i = 0; i < 10; i++)
      for (int b = 0; b < 4; b++) exp_q.push_back(8'(db_mem[i] >> (8 * b)));
    for (int i = 2; i < exp_q.size(); i++) model_csum = model_csum + exp_q[i];
    exp_q.push_back(model_csum);
  endtask

  task automatic check_frame(input string tag);
    int bad;
    bad = -1;
    check({tag, "_len"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      if (bad < 0 && cap_q[i] !== exp_q[i]) bad = i;
    check({tag, "_first_bad_index"}, bad, -1);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && dump_active; i++) @(negedge clk);
    check({tag, "_done"}, dump_active, 1'b0);
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && cap_q.size() < n; i++) @(negedge clk);
    check({tag, "_reached"}, (cap_q.size() >= n), 1'b1);
  endtask

  int n_hold;

  initial begin
    for (int i = 0; i < 36; i++) cw_mem[i] = 8'(i * 3 + 1);
    cb_mem[0] = 32'h11223344;
    for (int i = 1; i < 4; i++) cb_mem[i] = 32'hA0B0C0D0 + 32'(i);
    for (int i = 0; i < DW_N; i++) dw_mem[i] = 8'((i * 7) ^ (i >> 8));
    for (int i = 0; i < 10; i++) db_mem[i] = 32'h01020304 * 32'(i + 1);
    build_frame();

    rst = 1'b1;
    rx_data = 8'h00;
    rx_ready = 1'b0;
    weights_loaded = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_dump_active", dump_active, 1'b0);
    check("reset_tx_send", tx_send, 1'b0);
    check("reset_tx_data", tx_data, 8'h00);
    check("reset_addrs", {conv_w_addr, conv_b_addr, dense_w_addr, dense_b_addr}, 29'd0);
    check("reset_state", dbg_state, 3'd0);

    // Dump before weights are loaded: single error byte.
    cap_q.delete();
    rx_byte(8'hCE);
    check("err_active", dump_active, 1'b1);
    wait_done("err", 200);
    check("err_len", cap_q.size(), 1);
    check("err_byte", cap_q[0], 8'hEE);
    repeat (50) @(negedge clk);
    check("err_no_more", cap_q.size(), 1);
    check("err_idle_state", dbg_state, 3'd0);

    // Non-dump command in idle is ignored.
    weights_loaded = 1'b1;
    cap_q.delete();
    rx_byte(8'hCC);
    repeat (20) @(negedge clk);
    check("ignore_cc_active", dump_active, 1'b0);
    check("ignore_cc_bytes", cap_q.size(), 0);

    // Full frame, with commands injected mid-dump.
    cap_q.delete();
    rx_byte(8'hCE);
    check("frame_active", dump_active, 1'b1);
    wait_bytes("frame_mid", 500, 10000);
    rx_byte(8'hCE);
    rx_byte(8'hCC);
    wait_done("frame", 12000);
    check_frame("frame");
    check("frame_hdr0", cap_q[0], 8'hAA);
    check("frame_hdr1", cap_q[1], 8'h55);
    check("frame_cb0_le", {cap_q[41], cap_q[40], cap_q[39], cap_q[38]}, 32'h11223344);
    check("frame_csum", cap_q[FRAME_N-1], model_csum);
    repeat (200) @(negedge clk);
    check("frame_no_second_dump", cap_q.size(), FRAME_N);
    check("frame_idle_addrs", {conv_w_addr, conv_b_addr, dense_w_addr, dense_b_addr}, 29'd0);

    // Reset in the middle of a frame, then restart.
    cap_q.delete();
    rx_byte(8'hCE);
    wait_bytes("rst_mid", 1000, 10000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_active", dump_active, 1'b0);
    check("rst_mid_tx_data", tx_data, 8'h00);
    check("rst_mid_addrs", {conv_w_addr, conv_b_addr, dense_w_addr, dense_b_addr}, 29'd0);
    n_hold = cap_q.size();
    repeat (100) @(negedge clk);
    check("rst_mid_no_send", cap_q.size(), n_hold);
    cap_q.delete();
    rx_byte(8'hCE);
    wait_done("restart", 12000);
    check("restart_hdr0", cap_q[0], 8'hAA);
    check_frame("restart");

    // One byte held busy for 5000 cycles.
    cap_q.delete();
    hold_target = uart_sends + 300;
    rx_byte(8'hCE);
    wait_bytes("hold_start", 301, 10000);
    repeat (2) @(negedge clk);
    n_hold = cap_q.size();
    repeat (4900) @(negedge clk);
    check("hold_busy", tx_busy, 1'b1);
    check("hold_no_extra_send", cap_q.size(), n_hold);
    wait_done("hold", 20000);
    check_frame("hold");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
